// File: rtl/led_sched_pkg.sv
// rtl/led_sched_pkg.sv - shared state type, widths and round-robin search for the LED blink scheduler
package led_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    ON    = 3'd2,
    OFF   = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam int COUNT_W = 4;
  localparam int PHASE_W = 8;

  // First set bit at or above ptr, wrapping modulo n; descending scan so the
  // smallest offset from ptr is the last (and winning) assignment.
  function automatic int rr_pick(input logic [7:0] valid, input int ptr, input int n);
    int         pick;
    logic [2:0] idx;
    pick = 0;
    for (int i = 7; i >= 0; i--) begin
      if (i < n) begin
        idx = 3'((ptr + i) % n);
        if (valid[idx]) pick = int'(idx);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running clk divider emitting a one-cycle tick every TICK_DIV cycles
module tick_prescaler #(
  parameter int TICK_DIV = 6250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_blink_scheduler.sv
// rtl/led_blink_scheduler.sv - round-robin arbiter sharing one LED between blink requesters, with idle heartbeat
module led_blink_scheduler
  import led_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int TICK_DIV   = 6250000,
  parameter int ON_TICKS   = 2,
  parameter int OFF_TICKS  = 2,
  parameter int GAP_TICKS  = 4,
  parameter int IDLE_TICKS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [4*NUM_REQ-1:0]       req_count,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       led,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int GW = $clog2(NUM_REQ);

  state_t             state, state_n;
  logic [GW-1:0]      ptr, ptr_n, grant_id_n, winner;
  logic [COUNT_W-1:0] rem, rem_n;
  logic [PHASE_W-1:0] phase, phase_n, phase_lim;
  logic [NUM_REQ-1:0] ready_n;
  logic               led_n, tick, clr, phase_done;
  int                 win_idx;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .tick (tick)
  );

  assign win_idx    = rr_pick(8'(req_valid), int'(ptr), NUM_REQ);
  assign winner     = GW'(win_idx);
  assign phase_done = tick && (phase == phase_lim);
  // Every state change restarts both the prescaler and the phase tick count.
  assign clr        = (state_n != state);
  assign busy       = (state != IDLE);

  always_comb begin
    phase_lim = '0;
    unique case (state)
      IDLE:    phase_lim = PHASE_W'(IDLE_TICKS - 1);
      ON:      phase_lim = PHASE_W'(ON_TICKS - 1);
      OFF:     phase_lim = PHASE_W'(OFF_TICKS - 1);
      GAP:     phase_lim = PHASE_W'(GAP_TICKS - 1);
      default: phase_lim = '0;
    endcase
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    grant_id_n = grant_id;
    rem_n      = rem;
    led_n      = led;
    ready_n    = '0;
    phase_n    = tick ? phase + 1'b1 : phase;
    unique case (state)
      IDLE: begin
        if (|req_valid) begin
          state_n    = GRANT;
          grant_id_n = winner;
          rem_n      = req_count[{winner, 2'b00} +: COUNT_W];
          ready_n    = NUM_REQ'(1) << winner;
          led_n      = 1'b0;
        end else if (phase_done) begin
          led_n   = ~led;
          phase_n = '0;
        end
      end
      GRANT: begin
        ptr_n   = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        state_n = (rem == '0) ? IDLE : ON;
        led_n   = (rem != '0);
      end
      ON: begin
        if (phase_done) begin
          rem_n   = rem - 1'b1;
          state_n = OFF;
          led_n   = 1'b0;
        end
      end
      OFF: begin
        if (phase_done) begin
          state_n = (rem != '0) ? ON : GAP;
          led_n   = (rem != '0);
        end
      end
      GAP: begin
        if (phase_done) begin
          state_n = IDLE;
          led_n   = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        led_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_id  <= '0;
      rem       <= '0;
      phase     <= '0;
      led       <= 1'b0;
      req_ready <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      grant_id  <= grant_id_n;
      rem       <= rem_n;
      phase     <= clr ? '0 : phase_n;
      led       <= led_n;
      req_ready <= ready_n;
    end
  end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// tb/tb_led_blink_scheduler.sv - self-checking bench for led_blink_scheduler against an episode-level timing model
module tb_led_blink_scheduler;

  localparam int N     = 4;
  localparam int TD    = 4;
  localparam int ONT   = 2;
  localparam int OFFT  = 2;
  localparam int GAPT  = 3;
  localparam int IDLET = 8;
  localparam int ONC   = ONT * TD;
  localparam int BL    = (ONT + OFFT) * TD;
  localparam int GAPC  = GAPT * TD;
  localparam int HB    = IDLET * TD;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [4*N-1:0] req_count = '0;
  logic [N-1:0]   req_ready;
  logic           led, busy;
  logic [1:0]     grant_id;

  led_blink_scheduler #(
    .NUM_REQ(N), .TICK_DIV(TD), .ON_TICKS(ONT), .OFF_TICKS(OFFT),
    .GAP_TICKS(GAPT), .IDLE_TICKS(IDLET)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_count(req_count),
    .req_ready(req_ready), .led(led), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // An episode is one grant: GRANT cycle at ep_start, then count blinks and a gap.
  int   c, ep_start, ep_end, ep_id, ep_cnt, idle_start, m_ptr;
  bit   ep_on;
  logic e_led, e_busy;
  logic [N-1:0] e_ready;

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] counts;
    logic [3:0]  exp_ready;
    int          exp_gid;
    int          exp_busy;
    int          exp_rises;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, c, act, exp);
    end
  endtask

  task automatic model_reset();
    c = 0; ep_on = 0; idle_start = 0; m_ptr = 0; ep_id = 0; ep_cnt = 0;
  endtask

  task automatic model_close();
    if (ep_on && c >= ep_end) begin
      ep_on = 0;
      idle_start = ep_end;
    end
  endtask

  task automatic model_arb();
    int w;
    model_close();
    if (!ep_on && |req_valid) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      ep_on    = 1;
      ep_start = c + 1;
      ep_id    = w;
      ep_cnt   = int'(req_count[4*w +: 4]);
      ep_end   = ep_start + ((ep_cnt == 0) ? 1 : 1 + BL * ep_cnt + GAPC);
      m_ptr    = (w + 1) % N;
    end
  endtask

  task automatic model_out();
    int off;
    model_close();
    e_ready = '0;
    if (ep_on) begin
      off     = c - ep_start;
      e_busy  = 1'b1;
      e_ready = (off == 0) ? N'(1) << ep_id : '0;
      e_led   = (off >= 1) && (off - 1 < BL * ep_cnt) && ((off - 1) % BL < ONC);
    end else begin
      e_busy = 1'b0;
      e_led  = ((c - idle_start) / HB) % 2 == 1;
    end
  endtask

  task automatic step();
    model_arb();
    @(posedge clk);
    #1;
    c++;
    model_out();
    chk("led", led, e_led);
    chk("busy", busy, e_busy);
    chk("req_ready", req_ready, e_ready);
    chk("grant_id", grant_id, ep_id);
  endtask

  task automatic do_reset(input logic [3:0] v, input logic [15:0] cnts);
    rst_n = 1'b0;
    req_valid = v;
    req_count = cnts;
    #1;
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_gid", grant_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int first_rise, n, rises, busy_n, r0_pulses;
    logic prev;
    int got[5];
    int exp_order[5];

    tbl[0] = '{4'b0010, 16'h0030, 4'b0010, 1, 61, 3};
    tbl[1] = '{4'b0100, 16'h0000, 4'b0100, 2, 1, 0};
    tbl[2] = '{4'b1001, 16'h1001, 4'b1000, 3, 29, 1};
    tbl[3] = '{4'b1001, 16'h1001, 4'b0001, 0, 29, 1};
    tbl[4] = '{4'b0001, 16'h000F, 4'b0001, 0, 253, 15};
    tbl[5] = '{4'b1100, 16'h1200, 4'b0100, 2, 45, 2};
    exp_order = '{0, 1, 2, 3, 0};

    // Idle heartbeat after reset.
    do_reset(4'b0000, 16'h0000);
    first_rise = -1;
    prev = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (first_rise < 0 && led && !prev) first_rise = c;
      prev = led;
    end
    chk("hb_first_rise", first_rise, 32);

    // Single-request vectors from a known pointer.
    do_reset(4'b0000, 16'h0000);
    for (int v = 0; v < 6; v++) begin
      req_valid = tbl[v].valid;
      req_count = tbl[v].counts;
      for (int k = 0; k < 64; k++) begin
        step();
        if (req_ready != '0) break;
      end
      chk("vec_ready", req_ready, tbl[v].exp_ready);
      chk("vec_gid", grant_id, tbl[v].exp_gid);
      req_valid = '0;
      busy_n = busy ? 1 : 0;
      rises = 0;
      prev = led;
      for (int k = 0; k < 400; k++) begin
        step();
        if (!busy) break;
        busy_n++;
        if (led && !prev) rises++;
        prev = led;
      end
      chk("vec_busy_len", busy_n, tbl[v].exp_busy);
      chk("vec_blinks", rises, tbl[v].exp_rises);
    end

    // All requesters held from reset: fair rotation.
    do_reset(4'b1111, 16'h1111);
    n = 0;
    got = '{-1, -1, -1, -1, -1};
    for (int k = 0; k < 300 && n < 5; k++) begin
      step();
      if (req_ready != '0) begin
        got[n] = int'(grant_id);
        n++;
      end
    end
    for (int k = 0; k < 5; k++) chk("rr_order", got[k], exp_order[k]);

    // Asynchronous reset while the LED is lit, then pointer restarts at 0.
    do_reset(4'b0010, 16'h0020);
    for (int k = 0; k < 40; k++) begin
      step();
      if (req_ready[1]) req_valid = '0;
      if (e_led) break;
    end
    chk("pre_rst_led", led, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_led", led, 0);
    chk("async_busy", busy, 0);
    chk("async_ready", req_ready, 0);
    do_reset(4'b1001, 16'h1001);
    for (int k = 0; k < 8; k++) begin
      step();
      if (req_ready != '0) break;
    end
    chk("post_rst_ready", req_ready, 4'b0001);
    chk("post_rst_gid", grant_id, 0);
    req_valid = 4'b1000;
    for (int k = 0; k < 40; k++) step();

    // A request raised and dropped while another grant is playing is never seen.
    do_reset(4'b0010, 16'h0020);
    r0_pulses = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (req_ready[1]) begin
        req_valid = '0;
        break;
      end
    end
    for (int k = 0; k < 4; k++) step();
    req_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (req_ready[0]) r0_pulses++;
    end
    req_valid[0] = 1'b0;
    for (int k = 0; k < 80; k++) begin
      step();
      if (req_ready[0]) r0_pulses++;
    end
    chk("withdrawn_no_grant", r0_pulses, 0);

    // Randomised traffic; requesters hold until their own ready pulse.
    do_reset(4'b0000, 16'h0000);
    for (int k = 0; k < 3000; k++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (e_ready[i]) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && k < 2800 && $urandom_range(0, 29) == 0) begin
          req_valid[i] = 1'b1;
          req_count[4*i +: 4] = 4'($urandom_range(0, 3));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
